// File: rtl/axil_wr_arbiter.sv
// Round-robin arbiter sharing one AXI-lite write master among S_COUNT requesters.
// One AW+W+B transaction in flight; one idle cycle separates consecutive grants.
module axil_wr_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH/8,
   parameter int S_COUNT    = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [S_COUNT*ADDR_WIDTH-1:0]   s_axil_awaddr,
   input  logic [S_COUNT*3-1:0]            s_axil_awprot,
   input  logic [S_COUNT-1:0]              s_axil_awvalid,
   output logic [S_COUNT-1:0]              s_axil_awready,
   input  logic [S_COUNT*DATA_WIDTH-1:0]   s_axil_wdata,
   input  logic [S_COUNT*STRB_WIDTH-1:0]   s_axil_wstrb,
   input  logic [S_COUNT-1:0]              s_axil_wvalid,
   output logic [S_COUNT-1:0]              s_axil_wready,
   output logic [S_COUNT*2-1:0]            s_axil_bresp,
   output logic [S_COUNT-1:0]              s_axil_bvalid,
   input  logic [S_COUNT-1:0]              s_axil_bready,
   output logic [ADDR_WIDTH-1:0]           m_axil_awaddr,
   output logic [2:0]                      m_axil_awprot,
   output logic                            m_axil_awvalid,
   input  logic                            m_axil_awready,
   output logic [DATA_WIDTH-1:0]           m_axil_wdata,
   output logic [STRB_WIDTH-1:0]           m_axil_wstrb,
   output logic                            m_axil_wvalid,
   input  logic                            m_axil_wready,
   input  logic [1:0]                      m_axil_bresp,
   input  logic                            m_axil_bvalid,
   output logic                            m_axil_bready,
   output logic [S_COUNT-1:0]              grant
);
   localparam int IW = $clog2(S_COUNT);

   typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_RESP} state_t;

   state_t             r_state;
   logic [S_COUNT-1:0] r_grant;
   logic [IW-1:0]      r_gidx;
   logic [IW-1:0]      r_rr_ptr;
   logic               r_aw_done;
   logic               r_w_done;

   logic               w_pick_vld;
   logic [IW-1:0]      w_pick_idx;
   logic               w_sel_awvalid;
   logic               w_sel_wvalid;
   logic               w_sel_bready;
   logic               w_aw_hs;
   logic               w_w_hs;
   logic               w_b_hs;

   // Highest-priority requester is rr_ptr; scan downward so the lowest offset wins.
   always_comb begin
      w_pick_vld = 1'b0;
      w_pick_idx = '0;
      for (int k = S_COUNT-1; k >= 0; k--) begin
         if (s_axil_awvalid[(int'(r_rr_ptr) + k) % S_COUNT]) begin
            w_pick_vld = 1'b1;
            w_pick_idx = IW'((int'(r_rr_ptr) + k) % S_COUNT);
         end
      end
   end

   // Grant is one-hot or zero, so the mux outputs zero when nobody owns the port.
   always_comb begin
      m_axil_awaddr = '0;
      m_axil_awprot = '0;
      m_axil_wdata  = '0;
      m_axil_wstrb  = '0;
      w_sel_awvalid = 1'b0;
      w_sel_wvalid  = 1'b0;
      w_sel_bready  = 1'b0;
      for (int i = 0; i < S_COUNT; i++) begin
         if (r_grant[i]) begin
            m_axil_awaddr = s_axil_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            m_axil_awprot = s_axil_awprot[i*3 +: 3];
            m_axil_wdata  = s_axil_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            m_axil_wstrb  = s_axil_wstrb[i*STRB_WIDTH +: STRB_WIDTH];
            w_sel_awvalid = s_axil_awvalid[i];
            w_sel_wvalid  = s_axil_wvalid[i];
            w_sel_bready  = s_axil_bready[i];
         end
      end
   end

   assign m_axil_awvalid = (r_state == ST_DATA) && w_sel_awvalid && !r_aw_done;
   assign m_axil_wvalid  = (r_state == ST_DATA) && w_sel_wvalid && !r_w_done;
   assign m_axil_bready  = (r_state == ST_RESP) && w_sel_bready;
   assign grant          = r_grant;

   assign w_aw_hs = m_axil_awvalid && m_axil_awready;
   assign w_w_hs  = m_axil_wvalid && m_axil_wready;
   assign w_b_hs  = m_axil_bvalid && m_axil_bready;

   always_comb begin
      s_axil_awready = '0;
      s_axil_wready  = '0;
      s_axil_bvalid  = '0;
      s_axil_bresp   = '0;
      for (int i = 0; i < S_COUNT; i++) begin
         if (r_grant[i] && r_state == ST_DATA) begin
            s_axil_awready[i] = m_axil_awready && !r_aw_done;
            s_axil_wready[i]  = m_axil_wready && !r_w_done;
         end
         if (r_grant[i] && r_state == ST_RESP) begin
            s_axil_bvalid[i]      = m_axil_bvalid;
            s_axil_bresp[i*2 +: 2] = m_axil_bresp;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_grant   <= '0;
         r_gidx    <= '0;
         r_rr_ptr  <= '0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pick_vld) begin
                  r_grant <= S_COUNT'(1) << w_pick_idx;
                  r_gidx  <= w_pick_idx;
                  r_state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                  r_aw_done <= 1'b0;
                  r_w_done  <= 1'b0;
                  r_state   <= ST_RESP;
               end else begin
                  r_aw_done <= r_aw_done || w_aw_hs;
                  r_w_done  <= r_w_done || w_w_hs;
               end
            end
            ST_RESP: begin
               if (w_b_hs) begin
                  r_rr_ptr <= (r_gidx == IW'(S_COUNT-1)) ? '0 : r_gidx + IW'(1);
                  r_grant  <= '0;
                  r_state  <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axil_wr_arbiter.sv
// Bench for axil_wr_arbiter: vector table, directed multi-cycle sequences,
// and a randomized run scored against a transaction-level round-robin model.
module tb_axil_wr_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int S  = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [S*AW-1:0] s_awaddr;
   logic [S*3-1:0]  s_awprot;
   logic [S-1:0]    s_awvalid, s_awready;
   logic [S*DW-1:0] s_wdata;
   logic [S*SW-1:0] s_wstrb;
   logic [S-1:0]    s_wvalid, s_wready;
   logic [S*2-1:0]  s_bresp;
   logic [S-1:0]    s_bvalid, s_bready;
   logic [AW-1:0]   m_awaddr;
   logic [2:0]      m_awprot;
   logic            m_awvalid, m_awready;
   logic [DW-1:0]   m_wdata;
   logic [SW-1:0]   m_wstrb;
   logic            m_wvalid, m_wready;
   logic [1:0]      m_bresp;
   logic            m_bvalid, m_bready;
   logic [S-1:0]    grant;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   axil_wr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .S_COUNT(S)) dut (
      .clk(clk), .rst(rst),
      .s_axil_awaddr(s_awaddr), .s_axil_awprot(s_awprot), .s_axil_awvalid(s_awvalid),
      .s_axil_awready(s_awready), .s_axil_wdata(s_wdata), .s_axil_wstrb(s_wstrb),
      .s_axil_wvalid(s_wvalid), .s_axil_wready(s_wready), .s_axil_bresp(s_bresp),
      .s_axil_bvalid(s_bvalid), .s_axil_bready(s_bready),
      .m_axil_awaddr(m_awaddr), .m_axil_awprot(m_awprot), .m_axil_awvalid(m_awvalid),
      .m_axil_awready(m_awready), .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb),
      .m_axil_wvalid(m_wvalid), .m_axil_wready(m_wready), .m_axil_bresp(m_bresp),
      .m_axil_bvalid(m_bvalid), .m_axil_bready(m_bready), .grant(grant)
   );

   typedef struct {
      int          port;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [2:0]  prot;
      logic [1:0]  resp;
      logic [S-1:0] exp_grant;
      logic [1:0]  exp_bresp;
   } vec_t;

   vec_t vecs [4];

   // Requester / slave reference state for the randomized run.
   logic [S-1:0] rq_aw_pend, rq_w_pend, rq_aw_on, rq_w_on, rq_wait_b;
   logic [31:0]  rq_addr [S];
   logic [31:0]  rq_data [S];
   logic [3:0]   rq_strb [S];
   logic [2:0]   rq_prot [S];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      s_awaddr = '0; s_awprot = '0; s_awvalid = '0;
      s_wdata = '0; s_wstrb = '0; s_wvalid = '0; s_bready = '0;
      m_awready = 1'b0; m_wready = 1'b0; m_bresp = 2'b00; m_bvalid = 1'b0;
   endtask

   function automatic int rr_pick(input logic [S-1:0] req, input int ptr);
      for (int k = 0; k < S; k++)
         if (req[(ptr + k) % S]) return (ptr + k) % S;
      return -1;
   endfunction

   task automatic table_write(input vec_t v);
      s_awaddr[v.port*AW +: AW] = v.addr;
      s_awprot[v.port*3 +: 3]   = v.prot;
      s_wdata[v.port*DW +: DW]  = v.data;
      s_wstrb[v.port*SW +: SW]  = v.strb;
      s_awvalid[v.port] = 1'b1; s_wvalid[v.port] = 1'b1; s_bready[v.port] = 1'b1;
      m_awready = 1'b1; m_wready = 1'b1;
      #1 chk("vec.idle_awvalid", 64'(m_awvalid), 64'(0));
      tick();
      chk("vec.grant", 64'(grant), 64'(v.exp_grant));
      chk("vec.m_awvalid", 64'(m_awvalid), 64'(1));
      chk("vec.m_awaddr", 64'(m_awaddr), 64'(v.addr));
      chk("vec.m_awprot", 64'(m_awprot), 64'(v.prot));
      chk("vec.m_wdata", 64'(m_wdata), 64'(v.data));
      chk("vec.m_wstrb", 64'(m_wstrb), 64'(v.strb));
      chk("vec.s_awready", 64'(s_awready), 64'(v.exp_grant));
      tick();
      s_awvalid[v.port] = 1'b0; s_wvalid[v.port] = 1'b0;
      m_bvalid = 1'b1; m_bresp = v.resp;
      #1 chk("vec.m_awvalid_resp", 64'(m_awvalid), 64'(0));
      chk("vec.s_bvalid", 64'(s_bvalid), 64'(v.exp_grant));
      chk("vec.s_bresp", 64'(s_bresp[v.port*2 +: 2]), 64'(v.exp_bresp));
      chk("vec.m_bready", 64'(m_bready), 64'(1));
      tick();
      m_bvalid = 1'b0;
      #1 chk("vec.grant_idle", 64'(grant), 64'(0));
   endtask

   // Waits for the next grant, checks owner and address, then completes the write and re-requests.
   task automatic serve_one(input logic [S-1:0] eg, input logic [31:0] ea);
      int n = 0;
      int gp = 0;
      while (grant == '0 && n < 20) begin
         tick();
         n++;
      end
      chk("rr.grant", 64'(grant), 64'(eg));
      chk("rr.addr", 64'(m_awaddr), 64'(ea));
      for (int p = 0; p < S; p++) if (grant[p]) gp = p;
      tick();
      s_awvalid[gp] = 1'b0; s_wvalid[gp] = 1'b0;
      m_bvalid = 1'b1; m_bresp = 2'b00;
      #1 chk("rr.s_bvalid", 64'(s_bvalid), 64'(eg));
      tick();
      chk("rr.gap", 64'(grant), 64'(0));
      m_bvalid = 1'b0;
      s_awvalid[gp] = 1'b1; s_wvalid[gp] = 1'b1;
   endtask

   task automatic random_run(input int ntx);
      int own = -1, mrr = 0, started = 0, done = 0, aw_cnt = 0, w_cnt = 0;
      bit gap = 1'b0, sl_b_on = 1'b0;
      logic [1:0] sl_resp = 2'b00;
      logic [S-1:0] prev_awv, exp_g;
      rq_aw_pend = '0; rq_w_pend = '0; rq_aw_on = '0; rq_w_on = '0; rq_wait_b = '0;
      for (int cyc = 0; cyc < 6000; cyc++) begin
         if (started >= ntx && done == started) break;
         tick();
         prev_awv = s_awvalid;
         for (int p = 0; p < S; p++) begin
            if (!rq_aw_pend[p] && !rq_w_pend[p] && !rq_wait_b[p] && started < ntx
                && $urandom_range(0, 2) == 0) begin
               rq_addr[p] = $urandom; rq_data[p] = $urandom;
               rq_strb[p] = 4'($urandom_range(0, 15)); rq_prot[p] = 3'($urandom_range(0, 7));
               rq_aw_pend[p] = 1'b1; rq_w_pend[p] = 1'b1;
               started++;
            end
            if (rq_aw_pend[p] && !rq_aw_on[p] && $urandom_range(0, 1) == 1) rq_aw_on[p] = 1'b1;
            if (rq_w_pend[p] && !rq_w_on[p] && $urandom_range(0, 1) == 1) rq_w_on[p] = 1'b1;
            s_awvalid[p] = rq_aw_on[p];
            s_wvalid[p]  = rq_w_on[p];
            s_awaddr[p*AW +: AW] = rq_addr[p];
            s_awprot[p*3 +: 3]   = rq_prot[p];
            s_wdata[p*DW +: DW]  = rq_data[p];
            s_wstrb[p*SW +: SW]  = rq_strb[p];
            s_bready[p] = ($urandom_range(0, 3) != 0);
         end
         m_awready = 1'($urandom_range(0, 1));
         m_wready  = 1'($urandom_range(0, 1));
         if (!sl_b_on && aw_cnt == 1 && w_cnt == 1 && $urandom_range(0, 1) == 1) begin
            sl_b_on = 1'b1;
            sl_resp = 2'($urandom_range(0, 3));
         end
         m_bvalid = sl_b_on; m_bresp = sl_resp;
         #1;
         if (own < 0) begin
            if (gap) gap = 1'b0;
            else own = rr_pick(prev_awv, mrr);
         end
         exp_g = '0;
         if (own >= 0) exp_g[own] = 1'b1;
         chk("rnd.grant", 64'(grant), 64'(exp_g));
         chk("rnd.other_ports", 64'((s_awready | s_wready | s_bvalid) & ~exp_g), 64'(0));
         if (own < 0) begin
            chk("rnd.idle_m", 64'({m_awvalid, m_wvalid, m_bready}), 64'(0));
            continue;
         end
         chk("rnd.m_bready", 64'(m_bready),
             64'((aw_cnt == 1 && w_cnt == 1) ? s_bready[own] : 1'b0));
         if (m_awvalid && m_awready) begin
            chk("rnd.awaddr", 64'(m_awaddr), 64'(rq_addr[own]));
            chk("rnd.awprot", 64'(m_awprot), 64'(rq_prot[own]));
            chk("rnd.s_awready", 64'(s_awready[own]), 64'(1));
            aw_cnt++; rq_aw_pend[own] = 1'b0; rq_aw_on[own] = 1'b0;
         end
         if (m_wvalid && m_wready) begin
            chk("rnd.wdata", 64'({m_wstrb, m_wdata}), 64'({rq_strb[own], rq_data[own]}));
            chk("rnd.s_wready", 64'(s_wready[own]), 64'(1));
            w_cnt++; rq_w_pend[own] = 1'b0; rq_w_on[own] = 1'b0;
         end
         if (!rq_aw_pend[own] && !rq_w_pend[own] && aw_cnt == 1 && w_cnt == 1)
            rq_wait_b[own] = 1'b1;
         if (m_bvalid && m_bready) begin
            chk("rnd.s_bvalid", 64'(s_bvalid[own]), 64'(1));
            chk("rnd.s_bresp", 64'(s_bresp[own*2 +: 2]), 64'(sl_resp));
            chk("rnd.beats", 64'({aw_cnt[7:0], w_cnt[7:0]}), 64'(16'h0101));
            rq_wait_b[own] = 1'b0;
            mrr = (own + 1) % S;
            own = -1; gap = 1'b1; sl_b_on = 1'b0; aw_cnt = 0; w_cnt = 0;
            done++;
         end
      end
      chk("rnd.completed", 64'(done), 64'(ntx));
   endtask

   initial begin
      int wbeats;
      vecs[0] = '{0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b000, 2'b00, 2'b01, 2'b00};
      vecs[1] = '{1, 32'h0000_0020, 32'h1234_5678, 4'h3, 3'b101, 2'b01, 2'b10, 2'b01};
      vecs[2] = '{0, 32'h0000_0030, 32'hA5A5_A5A5, 4'h8, 3'b010, 2'b10, 2'b01, 2'b10};
      vecs[3] = '{1, 32'hFFFF_FFFC, 32'hCAFE_F00D, 4'hF, 3'b111, 2'b11, 2'b10, 2'b11};

      // Reset with every input trying to provoke activity.
      clear_inputs();
      rst = 1'b1;
      s_awvalid = '1; s_wvalid = '1; s_bready = '1;
      m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1;
      s_awaddr = {32'h0000_0200, 32'h0000_0100};
      repeat (3) tick();
      chk("reset.grant", 64'(grant), 64'(0));
      chk("reset.s_awready", 64'(s_awready), 64'(0));
      chk("reset.s_wready", 64'(s_wready), 64'(0));
      chk("reset.s_bvalid", 64'(s_bvalid), 64'(0));
      chk("reset.m_valids", 64'({m_awvalid, m_wvalid}), 64'(0));
      chk("reset.m_bready", 64'(m_bready), 64'(0));

      // Simultaneous requests at reset release: strict alternation 0,1,0,1.
      rst = 1'b0;
      m_bvalid = 1'b0;
      serve_one(2'b01, 32'h100);
      serve_one(2'b10, 32'h200);
      serve_one(2'b01, 32'h100);
      serve_one(2'b10, 32'h200);
      clear_inputs();
      tick(); tick();

      for (int i = 0; i < 4; i++) table_write(vecs[i]);

      // Port 1 presents W three cycles before AW; slave AW ready lags two cycles.
      clear_inputs();
      s_bready = '1; m_wready = 1'b1;
      s_wvalid[1] = 1'b1; s_wdata[DW +: DW] = 32'h5555_AAAA; s_wstrb[SW +: SW] = 4'hF;
      s_awaddr[AW +: AW] = 32'h300;
      wbeats = 0;
      repeat (3) begin
         #1 chk("wfirst.no_grant", 64'({grant, m_wvalid}), 64'(0));
         tick();
      end
      s_awvalid[1] = 1'b1;
      tick();
      chk("wfirst.grant", 64'(grant), 64'(2'b10));
      chk("wfirst.m_wdata", 64'(m_wdata), 64'(32'h5555_AAAA));
      chk("wfirst.readies", 64'({s_awready, s_wready}), 64'(4'b0010));
      if (m_wvalid && m_wready) wbeats++;
      tick();
      chk("wfirst.w_held", 64'({m_wvalid, s_wready, m_bready}), 64'(0));
      if (m_wvalid && m_wready) wbeats++;
      tick();
      m_awready = 1'b1;
      #1 chk("wfirst.aw_late", 64'({m_awvalid, s_awready, m_bready}), 64'(4'b1100));
      if (m_wvalid && m_wready) wbeats++;
      tick();
      s_awvalid = '0; s_wvalid = '0; m_bvalid = 1'b1; m_bresp = 2'b01;
      #1 chk("wfirst.s_bvalid", 64'({s_bvalid, s_bresp, m_bready}), 64'(7'b10_0100_1));
      chk("wfirst.one_beat", 64'(wbeats), 64'(1));
      tick();
      m_bvalid = 1'b0;
      #1 chk("wfirst.idle", 64'(grant), 64'(0));

      // Response backpressure with SLVERR while port 1 waits.
      clear_inputs();
      s_bready = 2'b10; m_awready = 1'b1; m_wready = 1'b1;
      s_awaddr[0 +: AW] = 32'h40; s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1;
      tick();
      s_awaddr[AW +: AW] = 32'h400; s_awvalid[1] = 1'b1; s_wvalid[1] = 1'b1;
      #1 chk("bp.grant0", 64'(grant), 64'(2'b01));
      tick();
      s_awvalid[0] = 1'b0; s_wvalid[0] = 1'b0; m_bvalid = 1'b1; m_bresp = 2'b10;
      repeat (4) begin
         #1 chk("bp.hold", 64'({grant, s_bvalid, s_bresp, m_bready}), 64'(9'b01_01_0010_0));
         tick();
      end
      s_bready[0] = 1'b1;
      #1 chk("bp.m_bready", 64'(m_bready), 64'(1));
      tick();
      m_bvalid = 1'b0;
      #1 chk("bp.idle", 64'(grant), 64'(0));
      tick();
      chk("bp.grant1", 64'(grant), 64'(2'b10));
      chk("bp.addr1", 64'(m_awaddr), 64'(32'h400));
      tick();
      s_awvalid[1] = 1'b0; s_wvalid[1] = 1'b0; m_bvalid = 1'b1; m_bresp = 2'b00;
      tick();
      m_bvalid = 1'b0;

      // Move the round-robin pointer to port 1, then reset in the middle of a port 1 write.
      table_write(vecs[0]);
      clear_inputs();
      s_bready = '1; m_awready = 1'b1;
      s_awaddr[AW +: AW] = 32'h500; s_awvalid[1] = 1'b1; s_wvalid[1] = 1'b1;
      tick();
      chk("midrst.grant", 64'(grant), 64'(2'b10));
      tick();
      s_awvalid[1] = 1'b0;
      #1 chk("midrst.aw_done", 64'({m_awvalid, m_wvalid}), 64'(2'b01));
      rst = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1;
      tick();
      chk("midrst.grant0", 64'(grant), 64'(0));
      chk("midrst.quiet", 64'({s_awready, s_wready, s_bvalid, m_awvalid, m_wvalid, m_bready}), 64'(0));
      rst = 1'b0;
      clear_inputs();
      s_bready = '1; m_awready = 1'b1; m_wready = 1'b1;
      s_awvalid = '1; s_wvalid = '1;
      tick();
      chk("midrst.rr_restart", 64'(grant), 64'(2'b01));
      tick();
      clear_inputs();
      s_bready = '1; m_bvalid = 1'b1;
      tick();
      clear_inputs();

      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      random_run(60);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
